// File: rtl/banco_pkg.sv
// banco_pkg: shared state type, default widths and port-slice helper for the register file
package banco_pkg;
   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   function automatic int lsb(input int port, input int width);
      return port * width;
   endfunction
endpackage

// File: rtl/banco_scoreboard.sv
// banco_scoreboard: per-register pending bits with reserve, write-release and sequential clear
module banco_scoreboard
   import banco_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1,
   localparam int DEPTH   = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_idx,
   output logic [DEPTH-1:0]  pend
);
   logic [DEPTH-1:0] pend_q, pend_d;
   always_comb begin
      pend_d = pend_q;
      if (clr_en) pend_d[clr_idx] = 1'b0;
      else begin
         if (we) pend_d[wa] = 1'b0;
         // reserve applied last so a new producer wins over a same-cycle write
         if (rsv_en) pend_d[rsv_addr] = 1'b1;
      end
      if (ZERO_REG != 0) pend_d[0] = 1'b0;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) pend_q <= '0;
      else pend_q <= pend_d;
   assign pend = pend_q;
endmodule

// File: rtl/banco_registros_param.sv
// banco_registros_param: multi-port register file with bypass, scoreboard and sequential clear engine
module banco_registros_param
   import banco_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int N_RD     = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_RD*ADDR_W-1:0]   ra,
   output logic [N_RD*DATA_W-1:0]   rd_data,
   output logic [N_RD-1:0]          rd_rdy,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wa,
   input  logic [DATA_W-1:0]        wd,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic                     clr_req,
   output logic                     busy
);
   localparam int DEPTH = 1 << ADDR_W;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic              wr_ok;
   assign busy  = state_q == ST_CLEAR;
   assign wr_ok = we && !busy;
   always_comb begin
      regs_d  = regs_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (busy) begin
         regs_d[cnt_q] = '0;
         cnt_d         = cnt_q + ADDR_W'(1);
         state_d       = (cnt_q == '1) ? ST_IDLE : ST_CLEAR;
      end else begin
         if (we && !(ZERO_REG != 0 && wa == '0)) regs_d[wa] = wd;
         if (clr_req) state_d = ST_CLEAR;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         regs_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         regs_q  <= regs_d;
      end
   banco_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .wa       (wa),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .clr_en   (busy),
      .clr_idx  (cnt_q),
      .pend     (pend)
   );
   for (genvar i = 0; i < N_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              zero, hit;
      assign a    = ra[lsb(i, ADDR_W) +: ADDR_W];
      assign zero = ZERO_REG != 0 && a == '0;
      assign hit  = BYPASS != 0 && wr_ok && wa == a;
      assign rd_data[lsb(i, DATA_W) +: DATA_W] = (rst || zero) ? '0 : hit ? wd : regs_q[a];
      assign rd_rdy[i] = rst ? 1'b1 : busy ? 1'b0 : (zero || !pend[a] || hit);
   end
endmodule

// File: tb/tb_banco_registros_param.sv
// tb_banco_registros_param: table vectors, clear/reset sequences and randomized model checks
module tb_banco_registros_param;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  ra = '0;
   logic [63:0] rd_data;
   logic [1:0]  rd_rdy;
   logic        we = 1'b0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;
   logic        rsv_en = 1'b0;
   logic [4:0]  rsv_addr = '0;
   logic        clr_req = 1'b0;
   logic        busy;

   banco_registros_param dut (
      .clk(clk), .rst(rst), .ra(ra), .rd_data(rd_data), .rd_rdy(rd_rdy),
      .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .clr_req(clr_req), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_regs [32];
   bit          m_pend [32];
   int          m_clear_left;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        rsv_en;
      logic [4:0]  rsv_addr;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  rdy;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 32; k++) begin
         m_regs[k] = '0;
         m_pend[k] = 1'b0;
      end
      m_clear_left = 0;
   endtask

   function automatic logic [31:0] exp_d(input int a);
      if (rst || a == 0) return '0;
      if (m_clear_left == 0 && we && int'(wa) == a) return wd;
      return m_regs[a];
   endfunction

   function automatic logic exp_r(input int a);
      if (rst) return 1'b1;
      if (m_clear_left != 0) return 1'b0;
      return a == 0 || !m_pend[a] || (we && int'(wa) == a);
   endfunction

   task automatic model_check(input string tag);
      chk({tag, " busy"}, 32'(busy), 32'(m_clear_left != 0));
      chk({tag, " d0"}, rd_data[31:0], exp_d(int'(ra[4:0])));
      chk({tag, " d1"}, rd_data[63:32], exp_d(int'(ra[9:5])));
      chk({tag, " rdy"}, 32'(rd_rdy), 32'({exp_r(int'(ra[9:5])), exp_r(int'(ra[4:0]))}));
   endtask

   // the clear zeroes registers in ascending order, one per cycle, for 32 cycles
   task automatic model_edge();
      if (m_clear_left != 0) begin
         m_regs[32 - m_clear_left] = '0;
         m_pend[32 - m_clear_left] = 1'b0;
         m_clear_left--;
      end else begin
         if (we && wa != 0) begin
            m_regs[wa] = wd;
            m_pend[wa] = 1'b0;
         end
         if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
         if (clr_req) m_clear_left = 32;
      end
   endtask

   task automatic tick(input string tag);
      #1;
      model_check(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      we = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
   endtask

   initial begin
      int n;
      vecs[0]  = '{0, 0, 0, 0, 0, 3, 0, 0, 0, 2'b11};
      vecs[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b11};
      vecs[2]  = '{0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b11};
      vecs[3]  = '{0, 0, 0, 1, 7, 5, 7, 32'hDEADBEEF, 0, 2'b11};
      vecs[4]  = '{0, 0, 0, 0, 0, 5, 7, 32'hDEADBEEF, 0, 2'b01};
      vecs[5]  = '{1, 7, 32'h12, 0, 0, 5, 7, 32'hDEADBEEF, 32'h12, 2'b11};
      vecs[6]  = '{0, 0, 0, 0, 0, 5, 7, 32'hDEADBEEF, 32'h12, 2'b11};
      vecs[7]  = '{1, 9, 32'hABCD, 1, 9, 9, 7, 32'hABCD, 32'h12, 2'b11};
      vecs[8]  = '{0, 0, 0, 0, 0, 9, 7, 32'hABCD, 32'h12, 2'b10};
      vecs[9]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 2'b11};
      vecs[10] = '{0, 0, 0, 0, 0, 0, 9, 0, 32'hABCD, 2'b01};
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("reset rdy", 32'(rd_rdy), 32'b11);
      chk("reset data", rd_data[31:0], 0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 11; v++) begin
         we = vecs[v].we; wa = vecs[v].wa; wd = vecs[v].wd;
         rsv_en = vecs[v].rsv_en; rsv_addr = vecs[v].rsv_addr;
         ra = {vecs[v].ra1, vecs[v].ra0};
         #1;
         chk($sformatf("vec%0d d0", v), rd_data[31:0], vecs[v].d0);
         chk($sformatf("vec%0d d1", v), rd_data[63:32], vecs[v].d1);
         chk($sformatf("vec%0d rdy", v), 32'(rd_rdy), 32'(vecs[v].rdy));
         chk($sformatf("vec%0d busy", v), 32'(busy), 0);
         tick($sformatf("vec%0d model", v));
      end

      // fill, pend a few, then clear and time it
      for (int k = 1; k < 32; k++) begin
         we = 1'b1; wa = 5'(k); wd = 32'h1000 + 32'(k);
         rsv_en = 1'b0;
         tick("fill");
      end
      idle_inputs();
      for (int k = 3; k < 32; k += 7) begin
         rsv_en = 1'b1; rsv_addr = 5'(k); ra = {5'(k), 5'(k - 1)};
         tick("pend");
      end
      idle_inputs();
      clr_req = 1'b1; ra = {5'd31, 5'd2};
      tick("clr start");
      clr_req = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         we = 1'b1; wa = 5'd30; wd = 32'h5555; rsv_en = 1'b1; rsv_addr = 5'd20;
         ra = {5'd30, 5'($urandom_range(0, 31))};
         chk("clear rdy", 32'(rd_rdy), 0);
         tick("clearing");
         n++;
      end
      idle_inputs();
      chk("clear length", 32'(n), 32);
      for (int k = 0; k < 32; k++) begin
         ra = {5'(31 - k), 5'(k)};
         #1;
         chk("post clear d0", rd_data[31:0], 0);
         chk("post clear rdy", 32'(rd_rdy), 32'b11);
         tick("post clear");
      end

      // reset in the middle of a clear
      for (int k = 1; k < 32; k++) begin
         we = 1'b1; wa = 5'(k); wd = 32'hA000 + 32'(k); rsv_en = 1'b1; rsv_addr = 5'(k);
         tick("refill");
      end
      idle_inputs();
      clr_req = 1'b1;
      tick("clr2 start");
      clr_req = 1'b0;
      repeat (10) tick("clr2 run");
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("mid rst busy", 32'(busy), 0);
      chk("mid rst d1", rd_data[63:32], 0);
      chk("mid rst rdy", 32'(rd_rdy), 32'b11);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 32; k++) begin
         ra = {5'(k), 5'(31 - k)};
         tick("after rst");
      end
      clr_req = 1'b1;
      tick("clr3 start");
      clr_req = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         tick("clr3 run");
         n++;
      end
      chk("clear after rst length", 32'(n), 32);

      // randomized traffic against the reference model
      for (int c = 0; c < 1500; c++) begin
         we = 1'($urandom_range(0, 1));
         wa = 5'($urandom_range(0, 31));
         wd = $urandom;
         rsv_en = 1'($urandom_range(0, 2) == 0);
         rsv_addr = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         clr_req = 1'($urandom_range(0, 79) == 0);
         ra[4:0] = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
         ra[9:5] = ($urandom_range(0, 3) == 0) ? ra[4:0] : 5'($urandom_range(0, 31));
         tick("rand");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
